// File: rtl/lc3b_types.sv
// lc3b_types: shared types for the LC-3b memory hierarchy.
//   arb_state_t  - mem_arbiter transaction state (IDLE, SERVE_I, SERVE_D)
//   lc3b_c_line  - one cache line (LC3B_LINE_W bits)
package lc3b_types;

    localparam int unsigned LC3B_LINE_W = 128;

    typedef logic [LC3B_LINE_W-1:0] lc3b_c_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_grant_select.sv
// arb_grant_select: combinational winner selection between the instruction
// and data cache miss requests.
//   i_ireq     in   instruction-cache request pending
//   i_dreq     in   data-cache request pending (read or write-back)
//   i_last_i   in   previous grant went to the instruction port
//                   (present only when ARB_ROUND_ROBIN_EN is defined)
//   o_grant_i  out  instruction port wins
//   o_grant_d  out  data port wins
// Macro ARB_ROUND_ROBIN_EN: alternate the winner on simultaneous requests;
// otherwise the data port always wins a tie.
module arb_grant_select
    import lc3b_types::*;
(
    input  logic i_ireq,
    input  logic i_dreq,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic i_last_i,
`endif
    output logic o_grant_i,
    output logic o_grant_d
);

    always_comb begin
        o_grant_i = 1'b0;
        o_grant_d = 1'b0;
        if (i_ireq && i_dreq) begin
`ifdef ARB_ROUND_ROBIN_EN
            // The port that was not served last time wins the tie.
            o_grant_d = i_last_i;
            o_grant_i = ~i_last_i;
`else
            o_grant_d = 1'b1;
`endif
        end else begin
            o_grant_i = i_ireq;
            o_grant_d = i_dreq;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single physical-memory port between the LC-3b
// instruction cache and data cache. One transaction at a time; the winner's
// command is driven to pmem until pmem_resp, whose pulse is routed back.
//   clk, reset_n                          clock, synchronous active-low reset
//   i_read, i_address                     instruction-cache line read request
//   i_rdata, i_resp                       line and completion pulse to I-cache
//   d_read, d_write, d_address, d_wdata   data-cache read / write-back request
//   d_rdata, d_resp                       line and completion pulse to D-cache
//   pmem_read, pmem_write, pmem_address,
//   pmem_wdata                            command to physical memory
//   pmem_rdata, pmem_resp                 response from physical memory
// Macro ARB_ROUND_ROBIN_EN: round-robin tie break via a last-grant register;
// undefined gives fixed data-over-instruction priority.
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    logic       r_d_write;
    logic       w_grant_i;
    logic       w_grant_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic       r_last_i;
`endif

    arb_grant_select u_grant (
        .i_ireq    (i_read),
        .i_dreq    (d_read | d_write),
`ifdef ARB_ROUND_ROBIN_EN
        .i_last_i  (r_last_i),
`endif
        .o_grant_i (w_grant_i),
        .o_grant_d (w_grant_d)
    );

    // The data command type is captured at grant so that a requester that
    // illegally drops its request still sees its command run to completion.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_d_write <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_grant_d) begin
                r_d_write <= d_write;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Reset value 1 makes the data port win the first tie.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last_i <= 1'b1;
        end else if (r_state == IDLE && (w_grant_i || w_grant_d)) begin
            r_last_i <= w_grant_i;
        end
    end
`endif

    always_comb begin
        w_next_state = r_state;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_next_state = SERVE_D;
                end else if (w_grant_i) begin
                    w_next_state = SERVE_I;
                end
            end
            SERVE_I: begin
                pmem_read    = 1'b1;
                pmem_address = i_address;
                if (pmem_resp) begin
                    i_resp       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            SERVE_D: begin
                pmem_write   = r_d_write;
                pmem_read    = ~r_d_write;
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
                if (pmem_resp) begin
                    d_resp       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(d_read && d_write))
            else $warning("mem_arbiter: d_read and d_write asserted together, write wins");
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import lc3b_types::*;

    localparam int unsigned AW = 16;
    localparam int unsigned LW = LC3B_LINE_W;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_read;
    logic [AW-1:0] i_address;
    lc3b_c_line    i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    lc3b_c_line    d_wdata;
    lc3b_c_line    d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    lc3b_c_line    pmem_wdata;
    lc3b_c_line    pmem_rdata;
    logic          pmem_resp;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: who owns the memory port (0 none, 1 I, 2 D),
    // whether the D transaction is a write, and who was served last.
    int m_owner  = 0;
    bit m_d_wr   = 1'b0;
    bit m_last_i = 1'b1;
    bit m_valid  = 1'b0;
    bit m_ir, m_dr;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_owner  = 0;
            m_last_i = 1'b1;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            if (m_owner != 0) begin
                if (pmem_resp) m_owner = 0;
            end else begin
                m_ir = i_read;
                m_dr = d_read | d_write;
                if (m_ir && m_dr) begin
`ifdef ARB_ROUND_ROBIN_EN
                    m_owner = m_last_i ? 2 : 1;
`else
                    m_owner = 2;
`endif
                end else if (m_dr) begin
                    m_owner = 2;
                end else if (m_ir) begin
                    m_owner = 1;
                end
                if (m_owner == 2) m_d_wr = d_write;
                if (m_owner != 0) m_last_i = (m_owner == 1);
            end
        end
    end

    logic          e_read, e_write, e_iresp, e_dresp;
    logic [AW-1:0] e_addr;
    lc3b_c_line    e_wdata;

    always @(negedge clk) begin
        if (m_valid) begin
            e_read  = (m_owner == 1) || (m_owner == 2 && !m_d_wr);
            e_write = (m_owner == 2) && m_d_wr;
            e_addr  = (m_owner == 1) ? i_address : (m_owner == 2) ? d_address : '0;
            e_wdata = (m_owner == 2) ? d_wdata : '0;
            e_iresp = (m_owner == 1) && pmem_resp;
            e_dresp = (m_owner == 2) && pmem_resp;
            chk("m_pmem_read",    pmem_read,    e_read);
            chk("m_pmem_write",   pmem_write,   e_write);
            chk("m_pmem_address", pmem_address, e_addr);
            chk("m_pmem_wdata",   pmem_wdata,   e_wdata);
            chk("m_i_resp",       i_resp,       e_iresp);
            chk("m_d_resp",       d_resp,       e_dresp);
            chk("m_i_rdata",      i_rdata,      pmem_rdata);
            chk("m_d_rdata",      d_rdata,      pmem_rdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cmd();
        for (int k = 0; k < 20; k++) begin
            if (pmem_read || pmem_write) return;
            step();
        end
        chk("cmd_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    lc3b_c_line line_a;
    lc3b_c_line line_b;
    logic [3:0] exp_d;
    bit         got_d;

    initial begin
        line_a = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
        line_b = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = 4'b0101;
`else
        exp_d = 4'b1111;
`endif
        reset_n    = 1'b0;
        i_read     = 1'b1;
        i_address  = 16'h1230;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_address  = '0;
        d_wdata    = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;

        // Reset with an instruction request held.
        step(); step();
        at_neg();
        chk("rst_pmem_read",  pmem_read,    1'b0);
        chk("rst_pmem_write", pmem_write,   1'b0);
        chk("rst_pmem_addr",  pmem_address, 16'h0000);
        chk("rst_i_resp",     i_resp,       1'b0);
        chk("rst_d_resp",     d_resp,       1'b0);
        step();
        reset_n = 1'b1;
        step();
        chk("rel_pmem_read", pmem_read,    1'b1);
        chk("rel_pmem_addr", pmem_address, 16'h1230);

        // Memory answers three cycles after the command.
        step(); step();
        pmem_resp  = 1'b1;
        pmem_rdata = line_a;
        at_neg();
        chk("i_resp_pulse", i_resp,  1'b1);
        chk("i_rdata_line", i_rdata, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
        chk("i_d_resp_low", d_resp,  1'b0);
        step();
        i_read    = 1'b0;
        pmem_resp = 1'b0;
        at_neg();
        chk("i_done_resp", i_resp,    1'b0);
        chk("i_done_read", pmem_read, 1'b0);

        // Stray pmem_resp while idle is ignored.
        pmem_resp = 1'b1;
        at_neg();
        chk("idle_resp_i", i_resp, 1'b0);
        chk("idle_resp_d", d_resp, 1'b0);
        step();
        pmem_resp = 1'b0;

        // Simultaneous I read and D write-back: data first, zero-wait memory.
        i_read    = 1'b1;
        i_address = 16'h0ABC;
        d_write   = 1'b1;
        d_address = 16'h4000;
        d_wdata   = line_b;
        step();
        chk("both_write",  pmem_write,   1'b1);
        chk("both_read0",  pmem_read,    1'b0);
        chk("both_addr",   pmem_address, 16'h4000);
        chk("both_wdata",  pmem_wdata,   128'h01234567_89ABCDEF_FEDCBA98_76543210);
        pmem_resp = 1'b1;
        at_neg();
        chk("both_d_resp", d_resp, 1'b1);
        chk("both_i_resp", i_resp, 1'b0);
        step();
        d_write   = 1'b0;
        pmem_resp = 1'b0;
        at_neg();
        chk("gap_read",  pmem_read,    1'b0);
        chk("gap_write", pmem_write,   1'b0);
        chk("gap_addr",  pmem_address, 16'h0000);
        step();
        chk("then_i_read", pmem_read,    1'b1);
        chk("then_i_addr", pmem_address, 16'h0ABC);
        pmem_resp = 1'b1;
        at_neg();
        chk("then_i_resp", i_resp, 1'b1);
        step();
        i_read    = 1'b0;
        pmem_resp = 1'b0;
        step();

        // D read request dropped mid-transaction still completes.
        d_read    = 1'b1;
        d_address = 16'h5550;
        step();
        chk("drop_read0", pmem_read, 1'b1);
        d_read = 1'b0;
        step();
        chk("drop_read1",  pmem_read,  1'b1);
        chk("drop_write",  pmem_write, 1'b0);
        pmem_resp = 1'b1;
        at_neg();
        chk("drop_d_resp", d_resp, 1'b1);
        step();
        pmem_resp = 1'b0;
        at_neg();
        chk("drop_idle", pmem_read, 1'b0);

        // Illegal read+write together: write wins.
        d_read    = 1'b1;
        d_write   = 1'b1;
        d_address = 16'h6000;
        step();
        chk("rw_write", pmem_write, 1'b1);
        chk("rw_read",  pmem_read,  1'b0);
        pmem_resp = 1'b1;
        at_neg();
        chk("rw_d_resp", d_resp, 1'b1);
        step();
        d_read    = 1'b0;
        d_write   = 1'b0;
        pmem_resp = 1'b0;
        step();

        // Reset in SERVE_D before the memory answers.
        d_write   = 1'b1;
        d_address = 16'h7000;
        step();
        chk("rstd_write0", pmem_write, 1'b1);
        reset_n = 1'b0;
        step();
        chk("rstd_write1", pmem_write, 1'b0);
        chk("rstd_d_resp", d_resp,     1'b0);
        chk("rstd_addr",   pmem_address, 16'h0000);
        d_write = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        // Both ports requesting continuously for four transactions.
        i_read    = 1'b1;
        i_address = 16'h1000;
        d_read    = 1'b1;
        d_address = 16'h2000;
        for (int t = 0; t < 4; t++) begin
            step();
            wait_cmd();
            got_d = (pmem_address == 16'h2000);
            chk($sformatf("arb_grant_%0d", t), got_d, exp_d[t]);
            pmem_resp = 1'b1;
            step();
            pmem_resp = 1'b0;
        end
        i_read = 1'b0;
        d_read = 1'b0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
